pll_supervisor: RTL
===================

// Module: pll_supervisor
// PURPOSE
//  Supervises one Gowin rPLL with dynamic dividers (DYN_IDIV_SEL/DYN_FBDIV_SEL "true").
//  Drives the PLL RESET and IDSEL/FBDSEL, filters LOCK, retries with timeout, and releases N_CH
//  downstream resets in a staggered sequence. Accepts runtime frequency-change requests.
//  Sits in the PLL reference-clock domain, between the board oscillator and the per-domain reset syncs.
// PARAMETERS
//  DEF_IDIV      4      IDIV_SEL applied after reset (input divide = DEF_IDIV+1)
//  DEF_FBDIV     15     FBDIV_SEL applied after reset (feedback multiply = DEF_FBDIV+1)
//  RESET_CYCLES  16     PLL RESET pulse width, clk cycles
//  LOCK_FILTER   64     consecutive synced-lock-high cycles required to declare lock
//  LOCK_TIMEOUT  25000  cycles allowed from PLL reset release to lock (1 ms at 25 MHz)
//  MAX_RETRY     3      failed lock attempts before FAIL
//  N_CH          2      number of sequenced reset outputs (>=1)
//  REL_GAP       8      cycles between successive channel releases (>=1)
// PORTS
//  clk            in   1       PLL reference clock
//  reset          in   1       async, active-high
//  pll_lock       in   1       raw LOCK from rPLL; asynchronous to clk
//  pll_reset      out  1       to rPLL RESET, active-high
//  pll_idsel      out  6       to rPLL IDSEL
//  pll_fbdsel     out  6       to rPLL FBDSEL
//  cfg_valid      in   1       reconfiguration request
//  cfg_ready      out  1       high only in RUN or FAIL
//  cfg_idiv       in   6       new IDIV_SEL
//  cfg_fbdiv      in   6       new FBDIV_SEL
//  locked         out  1       filtered lock
//  rst_out        out  N_CH    active-high downstream resets
//  fail           out  1       lock attempts exhausted
//  lock_loss_cnt  out  8       count of lock losses in RUN, saturates at 255
// BEHAVIOUR
//  Reset (async): state RESET_PLL, timer 0, retries 0.
//   Outputs: pll_reset=1, rst_out all 1, locked=0, fail=0, cfg_ready=0, lock_loss_cnt=0.
//   Selects: pll_idsel=~DEF_IDIV, pll_fbdsel=~DEF_FBDIV.
//  Encoding: all 6-bit; select = bitwise inverse of the divider setting.
//  Lock input: pll_lock goes through a 2-flop synchronizer (lock_s); the FSM uses only lock_s.
//  All outputs are registered.
//  FSM:
//  - RESET_PLL: pll_reset=1 for RESET_CYCLES cycles, then deassert, timer=0 -> WAIT_LOCK.
//  - WAIT_LOCK: timer++ each cycle.
//     lock_s=1 -> FILTER, filter count=0.
//     timer reaches LOCK_TIMEOUT -> retries++.
//       If retries==MAX_RETRY -> FAIL; else -> RESET_PLL.
//  - FILTER: count lock_s-high cycles; timer keeps running.
//     lock_s=0 -> WAIT_LOCK (count cleared, timer not cleared).
//     Timeout rule as WAIT_LOCK.
//     LOCK_FILTER reached -> locked=1, retries=0 -> RELEASE.
//  - RELEASE: rst_out[0]=0 on the first RELEASE cycle; rst_out[k] deasserts REL_GAP cycles after rst_out[k-1].
//     Release order is ascending.
//     After rst_out[N_CH-1] deasserts -> RUN.
//     lock_s=0 during RELEASE is treated as a lock loss (see RUN).
//  - RUN: cfg_ready=1.
//     lock_s=0 -> lock_loss_cnt++ (saturating), locked=0, rst_out all 1 next cycle -> RESET_PLL.
//  - FAIL: pll_reset=1, rst_out all 1, fail=1, locked=0, cfg_ready=1.
//     Left only by reset or by a cfg handshake.
//  Cfg handshake: accepted on cfg_valid && cfg_ready.
//   Next cycle: pll_idsel=~cfg_idiv, pll_fbdsel=~cfg_fbdiv.
//   Also: rst_out all 1, locked=0, fail=0, retries=0 -> RESET_PLL.
//   cfg_valid while cfg_ready=0 is ignored; no queuing.
//  Simultaneous cfg accept and lock loss in RUN: both take effect; count increments and the new selects apply.
//  Selects change only on a cfg accept or reset. pll_reset is always 1 in the cycle the selects change.
// TESTING
//  Params: RESET_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=100, MAX_RETRY=2, N_CH=3, REL_GAP=2.
//  1 Boot: pll_lock=1 from cycle 10 after reset.
//    -> pll_reset high 4 cycles; locked=1 after 2 sync + 8 filter cycles.
//    -> rst_out 111->110->100->000 at 2-cycle gaps; cfg_ready=1; selects 6'b111011/6'b110000.
//  2 Glitchy lock: 5-cycle lock pulses with 3-cycle gaps -> locked stays 0, no release.
//    Then steady lock -> nominal sequence.
//  3 No lock: pll_lock=0 -> two 4-cycle pll_reset pulses spaced by the 100-cycle timeout.
//    -> then fail=1, pll_reset=1, rst_out=111, cfg_ready=1.
//  4 Lock loss in RUN: drop pll_lock 1 cycle -> lock_loss_cnt=1, locked=0, rst_out=111, full re-sequence.
//    Repeat 300 times -> lock_loss_cnt saturates at 255.
//  5 Reconfig: cfg_idiv=1, cfg_fbdiv=7 in RUN -> pll_idsel=6'b111110, pll_fbdsel=6'b111000, pll_reset pulse, relock.
//    cfg_valid during RELEASE -> ignored. cfg in FAIL -> fail=0, retry.
//  6 Async reset asserted mid-RELEASE -> all outputs take reset values without waiting for a clk edge.

Source files
------------

// File: rtl/pll_supervisor_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_supervisor_if
// Description : Reconfiguration handshake bundle for pll_supervisor. The
//               requester (master) offers new divider settings; the
//               supervisor (slave) accepts them when it is ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_supervisor_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idiv;
  logic [5:0] cfg_fbdiv;

  modport master (output cfg_valid, output cfg_idiv, output cfg_fbdiv, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_idiv, input cfg_fbdiv, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_supervisor
// Description : Supervises one rPLL with dynamic dividers. Pulses the PLL
//               reset, filters LOCK, retries on timeout, releases N_CH
//               downstream resets in ascending staggered order and accepts
//               runtime divider changes. Lives in the reference-clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_supervisor #(
  parameter logic [5:0] DEF_IDIV     = 6'd4,
  parameter logic [5:0] DEF_FBDIV    = 6'd15,
  parameter int         RESET_CYCLES = 16,
  parameter int         LOCK_FILTER  = 64,
  parameter int         LOCK_TIMEOUT = 25000,
  parameter int         MAX_RETRY    = 3,
  parameter int         N_CH         = 2,
  parameter int         REL_GAP      = 8
) (
  input  wire              clk_i,
  input  wire              rst_i,
  input  wire              pll_lock_i,
  output logic             pll_reset_o,
  output logic [5:0]       pll_idsel_o,
  output logic [5:0]       pll_fbdsel_o,
  pll_supervisor_if.slave  cfg_if,
  output logic             locked_o,
  output logic [N_CH-1:0]  rst_out_o,
  output logic             fail_o,
  output logic [7:0]       lock_loss_cnt_o
);

  localparam int TMAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(LOCK_FILTER + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);
  localparam int GW   = $clog2(REL_GAP + 1);

  localparam logic [2:0] c_RESET_PLL = 3'd0;
  localparam logic [2:0] c_WAIT_LOCK = 3'd1;
  localparam logic [2:0] c_FILTER    = 3'd2;
  localparam logic [2:0] c_RELEASE   = 3'd3;
  localparam logic [2:0] c_RUN       = 3'd4;
  localparam logic [2:0] c_FAIL      = 3'd5;

  logic            lock_meta_q, lock_s_q;
  logic [2:0]      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic [RW-1:0]   retry_q, retry_d, retry_inc;
  logic [FW-1:0]   filt_q, filt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [N_CH-1:0] rst_out_q, rst_out_d;
  logic            locked_q, locked_d;
  logic            fail_q, fail_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic            pll_reset_q, pll_reset_d;
  logic [5:0]      idsel_q, idsel_d;
  logic [5:0]      fbdsel_q, fbdsel_d;
  logic [7:0]      loss_q, loss_d;
  logic            lock_lost;
  logic            cfg_accept;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_i;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Next-state logic: sequencing, lock loss and reconfiguration overrides
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    filt_d      = filt_q;
    gap_d       = gap_q;
    rst_out_d   = rst_out_q;
    locked_d    = locked_q;
    fail_d      = fail_q;
    pll_reset_d = pll_reset_q;
    idsel_d     = idsel_q;
    fbdsel_d    = fbdsel_q;
    loss_d      = loss_q;
    lock_lost   = 1'b0;
    cfg_accept  = cfg_if.cfg_valid && cfg_ready_q;
    timer_inc   = timer_q + TW'(1);
    retry_inc   = retry_q + RW'(1);

    case (state_q)
      c_RESET_PLL: begin
        if (timer_q == TW'(RESET_CYCLES - 1)) begin
          pll_reset_d = 1'b0;
          timer_d     = '0;
          state_d     = c_WAIT_LOCK;
        end else begin
          timer_d = timer_inc;
        end
      end
      c_WAIT_LOCK, c_FILTER: begin
        // The timeout window spans both states; dropping back out of
        // FILTER does not restart it.
        timer_d = timer_inc;
        if (timer_inc == TW'(LOCK_TIMEOUT)) begin
          retry_d     = retry_inc;
          filt_d      = '0;
          timer_d     = '0;
          pll_reset_d = 1'b1;
          if (retry_inc == RW'(MAX_RETRY)) begin
            fail_d  = 1'b1;
            state_d = c_FAIL;
          end else begin
            state_d = c_RESET_PLL;
          end
        end else if (state_q == c_WAIT_LOCK) begin
          if (lock_s_q) begin
            filt_d  = '0;
            state_d = c_FILTER;
          end
        end else if (!lock_s_q) begin
          filt_d  = '0;
          state_d = c_WAIT_LOCK;
        end else if (filt_q == FW'(LOCK_FILTER - 1)) begin
          // Lock declared: channel 0 leaves reset on the first RELEASE cycle
          locked_d  = 1'b1;
          retry_d   = '0;
          gap_d     = '0;
          rst_out_d = rst_out_q << 1;
          state_d   = (rst_out_d == '0) ? c_RUN : c_RELEASE;
        end else begin
          filt_d = filt_q + FW'(1);
        end
      end
      c_RELEASE: begin
        if (!lock_s_q) begin
          lock_lost = 1'b1;
        end else if (gap_q == GW'(REL_GAP - 1)) begin
          // Shifting zeros in from the bottom releases channels in ascending order
          gap_d     = '0;
          rst_out_d = rst_out_q << 1;
          if (rst_out_d == '0) begin
            state_d = c_RUN;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      c_RUN: begin
        if (!lock_s_q) begin
          lock_lost = 1'b1;
        end
      end
      default: begin
        // FAIL holds until reset or a reconfiguration request
      end
    endcase

    if (lock_lost) begin
      if (loss_q != 8'hFF) begin
        loss_d = loss_q + 8'd1;
      end
      locked_d    = 1'b0;
      rst_out_d   = '1;
      pll_reset_d = 1'b1;
      timer_d     = '0;
      gap_d       = '0;
      state_d     = c_RESET_PLL;
    end

    // A reconfiguration wins over everything else but still lets a
    // simultaneous lock loss be counted above.
    if (cfg_accept) begin
      idsel_d     = ~cfg_if.cfg_idiv;
      fbdsel_d    = ~cfg_if.cfg_fbdiv;
      rst_out_d   = '1;
      locked_d    = 1'b0;
      fail_d      = 1'b0;
      retry_d     = '0;
      filt_d      = '0;
      gap_d       = '0;
      timer_d     = '0;
      pll_reset_d = 1'b1;
      state_d     = c_RESET_PLL;
    end

    cfg_ready_d = (state_d == c_RUN) || (state_d == c_FAIL);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= c_RESET_PLL;
      timer_q     <= '0;
      retry_q     <= '0;
      filt_q      <= '0;
      gap_q       <= '0;
      rst_out_q   <= '1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
      pll_reset_q <= 1'b1;
      idsel_q     <= ~DEF_IDIV;
      fbdsel_q    <= ~DEF_FBDIV;
      loss_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      filt_q      <= filt_d;
      gap_q       <= gap_d;
      rst_out_q   <= rst_out_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      cfg_ready_q <= cfg_ready_d;
      pll_reset_q <= pll_reset_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      loss_q      <= loss_d;
    end
  end

  assign pll_reset_o      = pll_reset_q;
  assign pll_idsel_o      = idsel_q;
  assign pll_fbdsel_o     = fbdsel_q;
  assign cfg_if.cfg_ready = cfg_ready_q;
  assign locked_o         = locked_q;
  assign rst_out_o        = rst_out_q;
  assign fail_o           = fail_q;
  assign lock_loss_cnt_o  = loss_q;

endmodule
`default_nettype wire
